// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Desc    : MEM-stage data RAM target: RV32I byte/half/word loads and stores,
//           programmable wait states, one-cycle ready/error response.
//           Optional macro DMEM_MISALIGN_CHECK_EN rejects misaligned accesses.
// Rev     : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int          C_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] C_SPAN  = 33'(C_DEPTH) << 2;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_BUSY = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    localparam logic [2:0] C_F3_B  = 3'b000;
    localparam logic [2:0] C_F3_H  = 3'b001;
    localparam logic [2:0] C_F3_W  = 3'b010;
    localparam logic [2:0] C_F3_BU = 3'b100;
    localparam logic [2:0] C_F3_HU = 3'b101;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_rd;
    logic                  r_wr;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [C_DEPTH];

    logic                  w_start;
    logic                  w_commit;
    logic [31:0]           w_off;
    logic                  w_range_err;
    logic                  w_conflict;
    logic                  w_f3_ok;
    logic                  w_misalign;
    logic                  w_reject;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wlane;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    assign w_start  = mem_read | mem_write;
    assign w_commit = (r_state == C_ST_BUSY) && (r_cnt == 4'd0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = C_ST_BUSY;
                end
            end
            C_ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = C_ST_DONE;
                end
            end
            C_ST_DONE: begin
                w_state_nxt = C_ST_IDLE;
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_ready = (r_state == C_ST_DONE);
        read_data = r_rdata;
        mem_err   = r_err;
    end

    // Request capture and wait-state counter; inputs only matter in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
        end else if ((r_state == C_ST_IDLE) && w_start) begin
            r_cnt    <= 4'(WAIT_CYCLES);
            r_addr   <= address;
            r_wdata  <= w_data;
            r_funct3 <= funct3;
            r_rd     <= mem_read;
            r_wr     <= mem_write;
        end else if ((r_state == C_ST_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Request validation
    // ------------------------------------------------------------------------
    assign w_off       = r_addr - BASE_ADDR;
    assign w_range_err = (r_addr < BASE_ADDR) || ({1'b0, w_off} >= C_SPAN);
    assign w_conflict  = r_rd & r_wr;

    always_comb begin
        w_f3_ok = 1'b0;
        case (r_funct3)
            C_F3_B, C_F3_H, C_F3_W: w_f3_ok = 1'b1;
            C_F3_BU, C_F3_HU:       w_f3_ok = ~r_wr;
            default:                w_f3_ok = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (r_funct3[1:0])
            2'b01:   w_misalign = r_addr[0];
            2'b10:   w_misalign = (r_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = w_conflict | ~w_f3_ok | w_range_err | w_misalign;
    assign w_we     = w_commit & r_wr & ~w_reject;

    // ------------------------------------------------------------------------
    // Lane steering; without the alignment check the low bits are simply
    // ignored for the wider sizes.
    // ------------------------------------------------------------------------
    assign w_idx  = w_off[ADDR_WIDTH+1:2];
    assign w_lane = r_addr[1:0];

    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // RAM contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------------
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (r_funct3)
            C_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            C_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            C_F3_BU: w_load = {24'd0, w_byte};
            C_F3_HU: w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Response registers: loaded at commit, cleared on the edge leaving DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_reject;
            r_rdata <= (r_rd && !w_reject) ? w_load : 32'd0;
        end else if (r_state == C_ST_DONE) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Desc    : Self-checking bench for data_mem_responder against a byte-array
//           reference model. Honours DMEM_MISALIGN_CHECK_EN.
// Rev     : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int          AW   = 10;
    localparam int          WAIT = 2;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          LAT  = WAIT + 1;
    localparam int          NBYTES = 4 * (1 << AW);

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3    = 3'd0;
    logic [31:0] address   = 32'd0;
    logic [31:0] w_data    = 32'd0;
    logic [31:0] read_data;
    logic        mem_ready;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [NBYTES];

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .address   (address),
        .w_data    (w_data),
        .read_data (read_data),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    // Byte-addressed reference: legality, then read or write `size` bytes.
    function automatic void model_access(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] exp_data, output logic exp_err);
        int          size;
        logic [31:0] off;
        logic [31:0] val;
        bit          legal;
        size = 1 << f3[1:0];
        off  = a - BASE;
        if (rd && wr)  legal = 1'b0;
        else if (wr)   legal = (f3 <= 3'd2);
        else           legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        exp_err  = !legal || (a < BASE) || (off >= 32'(NBYTES));
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((a % size) != 0) exp_err = 1'b1;
`endif
        exp_data = 32'd0;
        if (exp_err) return;
        off = off - (off % size);
        if (wr) begin
            for (int i = 0; i < size; i++) model_mem[off + i] = wd[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val = val | (32'(model_mem[off + i]) << (8*i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
            exp_data = val;
        end
    endfunction

    // Drives one request from IDLE and returns what the DUT and the model say.
    task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] got_data, output logic got_err, output int lat,
                        output logic [31:0] exp_data, output logic exp_err,
                        output logic post_ready, output logic [31:0] post_data);
        model_access(rd, wr, f3, a, wd, exp_data, exp_err);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        address   = a;
        w_data    = wd;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        got_data = read_data;
        got_err  = mem_err;
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        @(posedge clk); #1;
        post_ready = mem_ready;
        post_data  = read_data;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_read  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", mem_err); end
        n_checks++; if (read_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", read_data); end
        mem_read = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        for (int w = 0; w < 64; w++) begin
            xact(1'b0, 1'b1, 3'b010, 32'(w * 4), 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
            n_checks++; if (lat !== LAT || e !== 1'b0) begin n_fail++; $display("FAIL init_sw[%0d]: got lat %0d err %b expected lat %0d err 0", w, lat, e, LAT); end
        end
    endtask

    task automatic test_word();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        xact(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL sw_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b expected 0", e); end
        n_checks++; if (pr !== 1'b0) begin n_fail++; $display("FAIL sw_ready_pulse: got %b expected 0", pr); end
        xact(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL lw_latency: got %0d expected %0d", lat, LAT); end
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", d); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b expected 0", e); end
        n_checks++; if (pr !== 1'b0 || pd !== 32'd0) begin n_fail++; $display("FAIL lw_after_done: got ready %b data %h expected 0 00000000", pr, pd); end
    endtask

    task automatic test_byte();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        xact(1'b0, 1'b1, 3'b000, 32'h13, 32'h80, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b expected 0", e); end
        xact(1'b1, 1'b0, 3'b000, 32'h13, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", d); end
        xact(1'b1, 1'b0, 3'b100, 32'h13, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h expected 00000080", d); end
        xact(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h80ADBEEF) begin n_fail++; $display("FAIL lw_after_sb: got %h expected 80adbeef", d); end
    endtask

    task automatic test_half();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        xact(1'b0, 1'b1, 3'b010, 32'h20, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        xact(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sh_err: got %b expected 0", e); end
        xact(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h12340000) begin n_fail++; $display("FAIL lw_after_sh: got %h expected 12340000", d); end
        xact(1'b1, 1'b0, 3'b101, 32'h22, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h00001234) begin n_fail++; $display("FAIL lhu_data: got %h expected 00001234", d); end
        xact(1'b1, 1'b0, 3'b001, 32'h20, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL lh_low: got %h expected 00000000", d); end
    endtask

    task automatic test_misalign();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        logic [31:0] want_d; logic want_e;
`ifdef DMEM_MISALIGN_CHECK_EN
        want_d = 32'h0;        want_e = 1'b1;
`else
        want_d = 32'h80ADBEEF; want_e = 1'b0;
`endif
        xact(1'b1, 1'b0, 3'b010, 32'h11, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== want_e) begin n_fail++; $display("FAIL lw_misalign_err: got %b expected %b", e, want_e); end
        n_checks++; if (d !== want_d) begin n_fail++; $display("FAIL lw_misalign_data: got %h expected %h", d, want_d); end
        xact(1'b1, 1'b0, 3'b001, 32'h23, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== ee || d !== ed) begin n_fail++; $display("FAIL lh_misalign: got err %b data %h expected err %b data %h", e, d, ee, ed); end
    endtask

    task automatic test_errors();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        xact(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL range_err: got err %b data %h expected err 1 data 00000000", e, d); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL range_latency: got %0d expected %0d", lat, LAT); end
        xact(1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL conflict_err: got err %b data %h expected err 1 data 00000000", e, d); end
        n_checks++; if (pr !== 1'b0 || pd !== 32'd0) begin n_fail++; $display("FAIL err_clear: got ready %b data %h expected 0 00000000", pr, pd); end
        xact(1'b0, 1'b1, 3'b100, 32'h10, 32'h22222222, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL store_f3_err: got %b expected 1", e); end
        xact(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL load_f3_err: got %b expected 1", e); end
        xact(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h80ADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL unchanged_after_err: got %h err %b expected 80adbeef err 0", d, e); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat; int seen;
        mem_write = 1'b1;
        funct3    = 3'b010;
        address   = 32'h30;
        w_data    = 32'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n   = 1'b0;
        mem_write = 1'b0;
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset: got %b expected 0", mem_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d ready pulses expected 0", seen); end
        xact(1'b1, 1'b0, 3'b010, 32'h30, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'h0 || lat !== LAT) begin n_fail++; $display("FAIL abort_ram_unchanged: got %h lat %0d expected 00000000 lat %0d", d, lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed, pd; logic e, ee, pr; int lat;
        xact(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (lat !== LAT || e !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got lat %0d err %b expected lat %0d err 0", lat, e, LAT); end
        n_checks++; if (pr !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ready %b expected 0", pr); end
        xact(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT); end
        xact(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, d, e, lat, ed, ee, pr, pd);
        n_checks++; if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_readback: got %h expected cafef00d", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, ed, pd, a, wd; logic e, ee, pr, rd, wr; logic [2:0] f3; int lat, sel;
        for (int n = 0; n < 120; n++) begin
            sel = int'($urandom_range(0, 9));
            rd  = (sel <= 5);
            wr  = (sel == 0) || (sel >= 6);
            f3  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 4095));
            else if (sel == 1) a = $urandom | 32'h8000_0000;
            else               a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            xact(rd, wr, f3, a, wd, 1'b0, d, e, lat, ed, ee, pr, pd);
            n_checks++;
            if (lat !== LAT || e !== ee || d !== ed) begin
                n_fail++;
                $display("FAIL rand[%0d] rd%b wr%b f3=%0d a=%h: got lat %0d err %b data %h expected lat %0d err %b data %h",
                         n, rd, wr, f3, a, lat, e, d, LAT, ee, ed);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
